// File: rtl/sonar_scheduler.sv
// sonar_scheduler
//   Round-robin sequencer that shares one pwm_measure instance among
//   N_SENSORS ultrasonic rangers. One trigger is fired at a time. The selected
//   sensor's synchronized echo is routed to pwm_measure, and the measured
//   distance is latched into a per-sensor slot when the echo ends. On timeout
//   the slot is loaded with 8'hFF instead.
// Ports
//   clk_i            system clock (10 MHz nominal)
//   reset_i          synchronous, active-high reset
//   enable_i         1 = keep scanning, 0 = stop after the current sensor
//   sensor_pwm_i     raw asynchronous echo, one bit per sensor
//   meas_distance_i  distance from the shared pwm_measure, inches
//   sensor_trig_o    per-sensor trigger; at most one bit is high
//   pwm_mux_o        selected synchronized echo, sent to pwm_measure.pwm_in
//   active_sel_o     index of the sensor being serviced
//   dist_out_o       latched distances; slot i = bits [8i+7:8i]
//   dist_valid_o     slot i holds a real (non-timeout) reading
//   sample_strobe_o  1-cycle pulse when any slot updates
//   timeout_flag_o   1-cycle pulse when a slot updates because of a timeout
module sonar_scheduler #(
  parameter int unsigned N_SENSORS      = 4,
  parameter int unsigned TRIG_CYCLES    = 250,
  parameter int unsigned TIMEOUT_CYCLES = 500_000,
  parameter int unsigned LATCH_DELAY    = 4,
  parameter int unsigned GAP_CYCLES     = 1000
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   enable_i,
  input  logic [N_SENSORS-1:0]   sensor_pwm_i,
  input  logic [7:0]             meas_distance_i,
  output logic [N_SENSORS-1:0]   sensor_trig_o,
  output logic                   pwm_mux_o,
  output logic [2:0]             active_sel_o,
  output logic [8*N_SENSORS-1:0] dist_out_o,
  output logic [N_SENSORS-1:0]   dist_valid_o,
  output logic                   sample_strobe_o,
  output logic                   timeout_flag_o
);

  localparam int unsigned SEL_W   = (N_SENSORS > 1) ? $clog2(N_SENSORS) : 1;
  localparam int unsigned TMO_W   = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned CNT_MAX =
      (TRIG_CYCLES >= GAP_CYCLES && TRIG_CYCLES >= LATCH_DELAY) ? TRIG_CYCLES :
      (GAP_CYCLES >= LATCH_DELAY) ? GAP_CYCLES : LATCH_DELAY;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0]     TRIG_LAST  = CNT_W'(TRIG_CYCLES - 1);
  localparam logic [CNT_W-1:0]     LATCH_LAST = CNT_W'(LATCH_DELAY - 1);
  localparam logic [CNT_W-1:0]     GAP_LAST   = CNT_W'(GAP_CYCLES - 1);
  localparam logic [TMO_W-1:0]     TMO_LAST   = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [SEL_W-1:0]     SEL_LAST   = SEL_W'(N_SENSORS - 1);
  localparam logic [N_SENSORS-1:0] TRIG_ONE   = N_SENSORS'(1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    TRIG      = 3'd1,
    WAIT_HIGH = 3'd2,
    WAIT_LOW  = 3'd3,
    SETTLE    = 3'd4,
    TMO       = 3'd5,
    GAP       = 3'd6
  } state_e;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [TMO_W-1:0]       tmo_cnt_q, tmo_cnt_d;
  logic [SEL_W-1:0]       sel_q, sel_d;
  logic [N_SENSORS-1:0]   sync1_q, sync2_q;
  logic [N_SENSORS-1:0]   trig_q, trig_d;
  logic                   mux_q, mux_d;
  logic                   strobe_q, strobe_d;
  logic                   tflag_q, tflag_d;
  logic [8*N_SENSORS-1:0] dist_q;
  logic [N_SENSORS-1:0]   valid_q;

  logic       echo_s;
  logic       tmo_hit;
  logic       slot_we;
  logic [7:0] slot_wdata;
  logic       slot_valid;

  // Two-flop synchronizer for every raw echo line
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sensor_pwm_i;
      sync2_q <= sync1_q;
    end
  end

  assign echo_s  = sync2_q[sel_q];
  assign tmo_hit = (tmo_cnt_q == TMO_LAST);

  // Next-state and registered-output logic
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tmo_cnt_d  = tmo_cnt_q;
    sel_d      = sel_q;
    slot_we    = 1'b0;
    slot_wdata = meas_distance_i;
    slot_valid = 1'b0;
    strobe_d   = 1'b0;
    tflag_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (enable_i) state_d = TRIG;
      end
      TRIG: begin
        tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        cnt_d     = cnt_q + CNT_W'(1);
        if (cnt_q == TRIG_LAST) begin
          cnt_d   = '0;
          state_d = WAIT_HIGH;
        end
      end
      WAIT_HIGH: begin
        tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        // An echo that is already high counts as the rising edge
        if (echo_s)       state_d = WAIT_LOW;
        else if (tmo_hit) state_d = TMO;
      end
      WAIT_LOW: begin
        tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        // The falling edge takes priority over a timeout in the same cycle
        if (!echo_s) begin
          cnt_d   = '0;
          state_d = SETTLE;
        end else if (tmo_hit) begin
          state_d = TMO;
        end
      end
      SETTLE: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LATCH_LAST) begin
          slot_we    = 1'b1;
          slot_wdata = meas_distance_i;
          slot_valid = 1'b1;
          strobe_d   = 1'b1;
          cnt_d      = '0;
          state_d    = GAP;
        end
      end
      TMO: begin
        slot_we    = 1'b1;
        slot_wdata = 8'hFF;
        slot_valid = 1'b0;
        strobe_d   = 1'b1;
        tflag_d    = 1'b1;
        cnt_d      = '0;
        state_d    = GAP;
      end
      GAP: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          sel_d   = (sel_q == SEL_LAST) ? '0 : sel_q + SEL_W'(1);
          state_d = enable_i ? TRIG : IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A fresh timeout window starts with every trigger
    if (state_d == TRIG && state_q != TRIG) begin
      tmo_cnt_d = '0;
      cnt_d     = '0;
    end

    trig_d = (state_d == TRIG) ? (TRIG_ONE << sel_d) : '0;
    mux_d  = (state_q == WAIT_HIGH || state_q == WAIT_LOW) ? echo_s : 1'b0;
  end

  // Control state registers
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      tmo_cnt_q <= '0;
      sel_q     <= '0;
      trig_q    <= '0;
      mux_q     <= 1'b0;
      strobe_q  <= 1'b0;
      tflag_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tmo_cnt_q <= tmo_cnt_d;
      sel_q     <= sel_d;
      trig_q    <= trig_d;
      mux_q     <= mux_d;
      strobe_q  <= strobe_d;
      tflag_q   <= tflag_d;
    end
  end

  // Result slots: only the slot of the serviced sensor is written
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      dist_q  <= '0;
      valid_q <= '0;
    end else begin
      for (int i = 0; i < int'(N_SENSORS); i++) begin
        if (slot_we && sel_q == SEL_W'(i)) begin
          dist_q[8*i +: 8] <= slot_wdata;
          valid_q[i]       <= slot_valid;
        end
      end
    end
  end

  assign sensor_trig_o   = trig_q;
  assign pwm_mux_o       = mux_q;
  assign active_sel_o    = 3'(sel_q);
  assign dist_out_o      = dist_q;
  assign dist_valid_o    = valid_q;
  assign sample_strobe_o = strobe_q;
  assign timeout_flag_o  = tflag_q;

endmodule

// File: tb/tb_sonar_scheduler.sv
// tb_sonar_scheduler
//   Bench for sonar_scheduler with four modelled rangers and a pwm_measure
//   model that converts pulse width to inches at 1470 cycles per inch.
module tb_sonar_scheduler;

  localparam int N    = 4;
  localparam int TRIG = 4;
  localparam int TMO  = 20000;
  localparam int LAT  = 4;
  localparam int GAP  = 10;
  localparam int INCH = 1470;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           enable = 1'b0;
  logic [N-1:0]   sensor_pwm = '0;
  logic [7:0]     meas_distance = '0;
  logic [N-1:0]   sensor_trig;
  logic           pwm_mux;
  logic [2:0]     active_sel;
  logic [8*N-1:0] dist_out;
  logic [N-1:0]   dist_valid;
  logic           sample_strobe;
  logic           timeout_flag;

  always #5 clk = ~clk;

  sonar_scheduler #(
    .N_SENSORS(N), .TRIG_CYCLES(TRIG), .TIMEOUT_CYCLES(TMO),
    .LATCH_DELAY(LAT), .GAP_CYCLES(GAP)
  ) dut (
    .clk_i(clk), .reset_i(reset), .enable_i(enable),
    .sensor_pwm_i(sensor_pwm), .meas_distance_i(meas_distance),
    .sensor_trig_o(sensor_trig), .pwm_mux_o(pwm_mux),
    .active_sel_o(active_sel), .dist_out_o(dist_out),
    .dist_valid_o(dist_valid), .sample_strobe_o(sample_strobe),
    .timeout_flag_o(timeout_flag)
  );

  typedef struct {
    int         sensor;
    int         echo_len;
    logic [7:0] exp_dist;
    logic       exp_valid;
    logic       exp_tmo;
  } vec_t;

  vec_t vecs[8];

  int       checks = 0;
  int       passes = 0;
  int       echo_len[N];
  int       dly[N];
  int       hi[N];
  int       twidth[N];
  logic [N-1:0] prev_trig = '0;
  logic     prev_mux = 1'b0;
  int       hcnt = 0;
  longint   cyc = 0;
  longint   last_rise_cyc = 0;
  int       trig_rises = 0;
  int       strobes = 0;
  int       tmos = 0;
  logic [7:0]   exp_slot[N];
  logic [N-1:0] exp_valid;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  function automatic logic [8*N-1:0] packed_slots();
    logic [8*N-1:0] r;
    for (int i = 0; i < N; i++) r[8*i +: 8] = exp_slot[i];
    return r;
  endfunction

  // Sensor, measurer and trigger monitors
  always @(negedge clk) begin
    cyc++;
    if (sample_strobe === 1'b1) strobes++;
    if (timeout_flag === 1'b1) tmos++;
    for (int i = 0; i < N; i++) begin
      if (sensor_trig[i] === 1'b1) begin
        if (!prev_trig[i]) begin
          trig_rises++;
          last_rise_cyc = cyc;
          check("trig_onehot", longint'($countones(sensor_trig)), 1);
        end
        twidth[i]++;
      end else if (prev_trig[i]) begin
        check("trig_width", twidth[i], TRIG);
        twidth[i] = 0;
        if (echo_len[i] > 0) begin
          dly[i] = 20;
          hi[i]  = echo_len[i];
        end
      end
      if (dly[i] > 0) begin
        dly[i]--;
        if (dly[i] == 0) sensor_pwm[i] = 1'b1;
      end else if (hi[i] > 0) begin
        hi[i]--;
        if (hi[i] == 0) sensor_pwm[i] = 1'b0;
      end
    end
    if (pwm_mux === 1'b1) begin
      hcnt++;
    end else if (prev_mux) begin
      meas_distance = 8'(hcnt / INCH);
      hcnt = 0;
    end
    prev_trig = sensor_trig;
    prev_mux  = (pwm_mux === 1'b1);
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_strobe(input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      tick();
      if (sample_strobe === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    check("strobe_seen", longint'(ok), 1);
  endtask

  task automatic wait_mux_sel(input int sel, input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      tick();
      if (pwm_mux === 1'b1 && int'(active_sel) == sel) begin
        ok = 1'b1;
        break;
      end
    end
    check("echo_window_seen", longint'(ok), 1);
  endtask

  task automatic check_result(input string tag, input int s, input logic [7:0] d,
                              input logic v, input logic t);
    exp_slot[s]  = d;
    exp_valid[s] = v;
    check({tag, "_sel"}, longint'(active_sel), s);
    check({tag, "_slot"}, longint'(dist_out[8*s +: 8]), longint'(d));
    check({tag, "_valid"}, longint'(dist_valid), longint'(exp_valid));
    check({tag, "_all_slots"}, longint'(dist_out), longint'(packed_slots()));
    check({tag, "_tmo_flag"}, longint'(timeout_flag), longint'(t));
  endtask

  initial begin
    bit     ok;
    int     rises_before;
    int     strobes_before;
    longint lat;

    vecs[0] = '{0, 1*INCH + 50, 8'd1,  1'b1, 1'b0};
    vecs[1] = '{1, 2*INCH + 50, 8'd2,  1'b1, 1'b0};
    vecs[2] = '{2, 3*INCH + 50, 8'd3,  1'b1, 1'b0};
    vecs[3] = '{3, 4*INCH + 50, 8'd4,  1'b1, 1'b0};
    vecs[4] = '{0, 5*INCH + 50, 8'd5,  1'b1, 1'b0};
    vecs[5] = '{1, 1*INCH + 50, 8'd1,  1'b1, 1'b0};
    vecs[6] = '{2, 0,           8'hFF, 1'b0, 1'b1};
    vecs[7] = '{3, 2*INCH + 50, 8'd2,  1'b1, 1'b0};

    for (int i = 0; i < N; i++) begin
      echo_len[i] = 0; dly[i] = 0; hi[i] = 0; twidth[i] = 0; exp_slot[i] = '0;
    end
    exp_valid = '0;

    // Reset with enable low: everything idle
    repeat (10) @(posedge clk);
    tick();
    reset = 1'b0;
    tick();
    check("rst_trig", longint'(sensor_trig), 0);
    check("rst_mux", longint'(pwm_mux), 0);
    check("rst_sel", longint'(active_sel), 0);
    check("rst_dist", longint'(dist_out), 0);
    check("rst_valid", longint'(dist_valid), 0);
    check("rst_strobe", longint'(sample_strobe), 0);
    check("rst_tmo", longint'(timeout_flag), 0);
    repeat (1000) tick();
    check("idle_no_trig", trig_rises, 0);

    // Continuous scan driven by the vector table, two full passes
    for (int i = 0; i < 8; i++) begin
      echo_len[vecs[i].sensor] = vecs[i].echo_len;
      if (i == 0) enable = 1'b1;
      wait_strobe(30000, ok);
      if (vecs[i].exp_tmo) begin
        lat = cyc - last_rise_cyc;
        check("tmo_latency_in_range", longint'(lat >= TMO - 5 && lat <= TMO + 5), 1);
      end
      check_result($sformatf("vec%0d", i), vecs[i].sensor, vecs[i].exp_dist,
                   vecs[i].exp_valid, vecs[i].exp_tmo);
      check($sformatf("vec%0d_strobe_count", i), strobes, i + 1);
    end
    check("tmo_pulse_count", tmos, 1);

    // Enable dropped while sensor 1 is mid-echo
    echo_len[0] = 1*INCH + 50;
    echo_len[1] = 3*INCH + 50;
    wait_strobe(30000, ok);
    check_result("en_s0", 0, 8'd1, 1'b1, 1'b0);
    wait_mux_sel(1, 10000, ok);
    enable = 1'b0;
    wait_strobe(30000, ok);
    check_result("en_s1", 1, 8'd3, 1'b1, 1'b0);
    rises_before   = trig_rises;
    strobes_before = strobes;
    repeat (GAP + 5) tick();
    check("en_sel_advanced", longint'(active_sel), 2);
    repeat (2000) tick();
    check("en_no_new_trig", trig_rises, rises_before);
    check("en_trig_low", longint'(sensor_trig), 0);
    check("en_no_new_strobe", strobes, strobes_before);

    // Reset during sensor 3 echo
    echo_len[2] = 1*INCH + 50;
    echo_len[3] = 3*INCH + 50;
    enable = 1'b1;
    wait_strobe(30000, ok);
    check_result("rs_s2", 2, 8'd1, 1'b1, 1'b0);
    wait_mux_sel(3, 10000, ok);
    reset = 1'b1;
    tick();
    for (int i = 0; i < N; i++) exp_slot[i] = '0;
    exp_valid = '0;
    check("rs_trig", longint'(sensor_trig), 0);
    check("rs_valid", longint'(dist_valid), 0);
    check("rs_sel", longint'(active_sel), 0);
    check("rs_dist", longint'(dist_out), 0);
    check("rs_mux", longint'(pwm_mux), 0);
    repeat (3) tick();
    echo_len[0] = 2*INCH + 50;
    reset = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (sensor_trig !== '0) begin
        ok = 1'b1;
        break;
      end
    end
    check("rs_restart_seen", longint'(ok), 1);
    check("rs_restart_s0", longint'(sensor_trig), 1);
    wait_strobe(30000, ok);
    check_result("rs_s0", 0, 8'd2, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
